// File: rtl/tt_check_pkg.sv
// Shared types and defaults for the truth-table sweep-and-compare checker.
package tt_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } tt_state_t;

    localparam int TT_N_IN   = 3;
    localparam int TT_SETTLE = 1;

    // Settle counter value at which WAIT hands over to CHECK. SETTLE is
    // meant to stay within 1..15; out-of-range values are pulled back to
    // the nearest legal setting so the 4-bit counter never overflows.
    function automatic logic [3:0] tt_settle_last(input int settle);
        if (settle <= 1) begin
            return 4'd0;
        end else if (settle >= 15) begin
            return 4'd14;
        end else begin
            return 4'(settle - 1);
        end
    endfunction

endpackage

// File: rtl/vec_sweep_counter.sv
// Input-vector counter for the sweep: clears to zero, steps on request and
// flags the all-ones vector so the checker knows the sweep is complete.
module vec_sweep_counter
    import tt_check_pkg::*;
#(
    parameter int N_IN = TT_N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            inc,
    output logic [N_IN-1:0] count,
    output logic            last
);

    // Vector register: clear wins over increment, so a fresh sweep always
    // starts at zero even if both strobes arrive together.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign last = &count;

endmodule

// File: rtl/truth_table_checker.sv
// Clocked sweep-and-compare engine: drives every input vector onto the
// question (POS) and answer (SOP) functions, waits for them to settle,
// compares the two outputs and reports mismatch count and first failure.
module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int N_IN   = TT_N_IN,
    parameter int SETTLE = TT_SETTLE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    input  logic            m_q,
    input  logic            m_an,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_cnt,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam logic [3:0] SETTLE_LAST = tt_settle_last(SETTLE);
    localparam int         CW          = N_IN + 1;

    tt_state_t         state;
    logic [3:0]        settle_cnt;
    logic              clear_vec;
    logic              inc_vec;
    logic              last_vec;
    logic              differ;
    logic [CW-1:0]     cnt_next;

    // The count after this CHECK cycle is needed both to update the
    // register and to decide pass on the terminal vector.
    assign differ    = m_q ^ m_an;
    assign cnt_next  = mismatch_cnt + CW'(differ);
    assign clear_vec = ((state == IDLE) || (state == DONE)) && start;
    assign inc_vec   = (state == CHECK) && !last_vec;

    vec_sweep_counter #(
        .N_IN (N_IN)
    ) u_sweep (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_vec),
        .inc   (inc_vec),
        .count (vec),
        .last  (last_vec)
    );

    // Sweep controller: start is only honoured when not sweeping, so a
    // stray pulse mid-sweep can neither restart nor stretch the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            settle_cnt       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= WAIT;
                        settle_cnt       <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        mismatch_cnt     <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end
                WAIT: begin
                    settle_cnt <= settle_cnt + 4'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (differ) begin
                        mismatch_cnt <= cnt_next;
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= vec;
                        end
                    end
                    if (last_vec) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (cnt_next == '0);
                    end else begin
                        state      <= WAIT;
                        settle_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
